vga_sprite_mixer: RTL
=====================

# vga_sprite_mixer

Parametrised successor to the single-rectangle draw stage and its hand-written delay stages. It overlays `N_SPR` ROM-backed image sprites on the VGA stream coming from the background stage, with fixed priority and a frame-synchronous position latch. It contains its own aligned delay of the timing signals. It sits between `draw_bg` and `draw_mouse` in the 40 MHz `clk` domain.

## Interface
Parameters:
- `N_SPR`, default 2, number of sprites (1..4); index 0 has the highest priority.
- `SPR_W`, default 48, sprite width in pixels; must be ≤ 2^`COL_BITS`.
- `SPR_H`, default 64, sprite height in pixels; must be ≤ 2^`ROW_BITS`.
- `COL_BITS`, default 6, column field width of the ROM address.
- `ROW_BITS`, default 6, row field width of the ROM address.
- `ROM_LAT`, default 1, cycles from `pixel_addr` to valid `rgb_pixel` (1..3).
- `KEY_RGB`, default 12'hF0F, transparent colour; used only when color-keying is compiled in.

Ports:
- `clk`  in  1  pixel clock; the block has one clock.
- `rst`  in  1  synchronous, active-high reset.
- `vii`  in  `vga_if`  stream input: vcount/hcount 11 b, vsync/hsync, vblnk/hblnk, rgb 12 b.
- `vio`  out  `vga_if`  stream output, same fields.
- `xpos`  in  `N_SPR`×12  sprite left edge, unsigned pixels.
- `ypos`  in  `N_SPR`×12  sprite top edge, unsigned pixels.
- `spr_en`  in  `N_SPR`  per-sprite enable.
- `pixel_addr`  out  `N_SPR`×(`ROW_BITS`+`COL_BITS`)  ROM address per sprite.
- `rgb_pixel`  in  `N_SPR`×12  ROM data per sprite.
- `frame_tick`  out  1  one-cycle pulse when positions are latched.

## Operation
- **Position latch**
  - Register `vii.vblnk` and detect its rising edge.
  - On that cycle, copy `xpos`/`ypos`/`spr_en` into shadow registers and pulse `frame_tick`.
  - Shadow values are used for the whole following frame, so there is no tearing.
- **Stage A (1 cycle)**, per sprite i:
  - Hit condition: `hcount` ≥ x_i and `hcount` < x_i+`SPR_W` and `vcount` ≥ y_i and `vcount` < y_i+`SPR_H` and en_i.
  - Do the sum in 13 bits and zero-extend the counts to 13 bits. There is no wrap-around; a sprite partly past 4095 is simply clipped.
  - `pixel_addr[i]` = {(vcount−y_i)[ROW_BITS-1:0], (hcount−x_i)[COL_BITS-1:0]}, registered. It is driven 0 when there is no hit.
  - Register the hit flags.
- **Delay**: hit flags are delayed `ROM_LAT` cycles so they align with `rgb_pixel`.
- **Stage C (1 cycle) mix**:
  - If `vblnk` or `hblnk` (aligned copy) is set, pass the aligned input rgb through unchanged.
  - Otherwise take the lowest-index sprite that hits (and, when keyed, is not transparent); if none, take the background rgb.
- **Timing fields**: all fields except rgb are delayed by exactly the total latency and are not modified.

## Timing
- Total latency L = `ROM_LAT` + 2 cycles for every `vio` field relative to `vii`. The default L is 3.
- `pixel_addr` is valid 1 cycle after `vii`. ROM data is sampled `ROM_LAT` cycles later.
- Reset values:
  - All `vio` fields are 0.
  - `pixel_addr` is 0 and `frame_tick` is 0.
  - Shadow positions are 0 and shadow enables are 0, so all sprites are off.
  - All delay-line contents are 0.
- Reset mid-frame: outputs follow the above. No sprite draws until the next `vblnk` rising edge after reset is released.
- Two sprites hitting the same pixel: the lower index wins.
- `spr_en` changing mid-frame has no effect until the next latch.
- `vblnk` held high at reset release: no edge is seen, so no latch happens until the next genuine rising edge.

## Configuration
- `SPRITE_COLOR_KEY_EN` defined:
  - A sprite pixel equal to `KEY_RGB` counts as transparent.
  - Mixing falls to the next-priority hit sprite, then to the background.
- Undefined: every hit pixel is opaque, and `KEY_RGB` is ignored.

## Structure
- `vga_pkg` holds:
  - the `SPR_MAX` (4) constant and the 12-bit rgb typedef;
  - a `vga_tim_t` struct bundling vcount, hcount, vsync, hsync, vblnk and hblnk.
- Sub-module `vga_pipe_delay`: a parametrised-depth shift register for `vga_tim_t` plus rgb. It is instantiated once with depth L and replaces the ad-hoc wait stages.

## Test plan
- **Latency**: `N_SPR`=2, all sprites disabled, `ROM_LAT`=1 → `vio` equals `vii` delayed exactly 3 cycles in every field.
- **Single sprite**: sprite 0 at (100,200), ROM data = address → at hcount 100, vcount 200, `pixel_addr[0]`=0. At (147,263) the address is {63,47} = 12'hFEF. Pixels (148,263) and (100,264) show the background.
- **Priority**: sprite 0 at (10,10) and sprite 1 at (20,20) overlap → pixel (30,30) shows sprite 0 data. With `spr_en[0]`=0, it shows sprite 1 data.
- **Frame latch**: change `xpos[0]` from 100 to 300 mid-frame → the drawn position stays 100 until `frame_tick`, and the next frame draws at 300.
- **Color key** (`SPRITE_COLOR_KEY_EN`): sprite 0 returns 12'hF0F over sprite 1 returning 12'h0F0 → output 12'h0F0. With only sprite 0 present, output is the background rgb.
- **Reset and clipping**:
  - Assert `rst` mid-line → all `vio` fields are 0 on the next edge, and no sprite is drawn until the following vblank edge.
  - Sprite at x=4090 → no hit and no wrap to x=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA sprite pipeline.
//   SPR_MAX   : largest supported sprite count
//   rgb_t     : 12-bit 4:4:4 colour
//   vga_tim_t : the timing fields of the VGA stream (everything except rgb)
//   in_span   : non-wrapping range test used for sprite hit detection
package vga_pkg;

  localparam int unsigned SPR_MAX = 4;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
  } vga_tim_t;

  // True when org <= pos < org + len. Done in 13 bits so a sprite hanging past 4095 is
  // clipped rather than wrapping round to column/row 0.
  function automatic logic in_span(logic [10:0] pos, logic [11:0] org, int unsigned len);
    logic [12:0] pos_ext;
    logic [12:0] org_ext;
    pos_ext = {2'b00, pos};
    org_ext = {1'b0, org};
    return (pos_ext >= org_ext) && (pos_ext < org_ext + 13'(len));
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA stream bundle passed between draw stages.
//   in  : consumer view (all fields are inputs)
//   out : producer view (all fields are outputs)
interface vga_if;

  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);

endinterface

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register for the VGA timing fields plus rgb.
//   clk_i  : pixel clock
//   rst_i  : synchronous active-high reset, clears every stage to 0
//   tim_i  : timing fields in
//   rgb_i  : rgb in
//   tim_o  : timing fields, Depth cycles later
//   rgb_o  : rgb, Depth cycles later
module vga_pipe_delay
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 3
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  vga_tim_t tim_i,
  input  rgb_t     rgb_i,
  output vga_tim_t tim_o,
  output rgb_t     rgb_o
);

  vga_tim_t tim_q [Depth];
  rgb_t     rgb_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < Depth; k++) begin
        tim_q[k] <= '0;
        rgb_q[k] <= '0;
      end
    end else begin
      tim_q[0] <= tim_i;
      rgb_q[0] <= rgb_i;
      for (int k = 1; k < Depth; k++) begin
        tim_q[k] <= tim_q[k-1];
        rgb_q[k] <= rgb_q[k-1];
      end
    end
  end

  assign tim_o = tim_q[Depth-1];
  assign rgb_o = rgb_q[Depth-1];

endmodule

// File: rtl/vga_sprite_mixer.sv
// Overlays N_SPR ROM-backed sprites on the VGA stream with fixed priority (index 0 on top).
// Sprite positions/enables are shadowed on the rising edge of vblnk so a frame never tears.
// Every vio field lags vii by ROM_LAT + 2 cycles.
//   clk, rst   : pixel clock, synchronous active-high reset
//   vii / vio  : VGA stream in / out
//   xpos, ypos : per-sprite top-left corner, spr_en : per-sprite enable
//   pixel_addr : per-sprite ROM address {row, col}, registered, 0 when not hit
//   rgb_pixel  : per-sprite ROM data, ROM_LAT cycles after pixel_addr
//   frame_tick : one-cycle pulse as the shadow positions take new values
// Build option: define SPRITE_COLOR_KEY_EN to treat sprite pixels equal to KEY_RGB as
// transparent; otherwise every hit pixel is opaque.
module vga_sprite_mixer
  import vga_pkg::*;
#(
  parameter int unsigned N_SPR    = 2,
  parameter int unsigned SPR_W    = 48,
  parameter int unsigned SPR_H    = 64,
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned ROW_BITS = 6,
  parameter int unsigned ROM_LAT  = 1,
  parameter logic [11:0] KEY_RGB  = 12'hF0F
) (
  input  logic                                     clk,
  input  logic                                     rst,
  vga_if.in                                        vii,
  vga_if.out                                       vio,
  input  logic [N_SPR-1:0][11:0]                   xpos,
  input  logic [N_SPR-1:0][11:0]                   ypos,
  input  logic [N_SPR-1:0]                         spr_en,
  output logic [N_SPR-1:0][ROW_BITS+COL_BITS-1:0]  pixel_addr,
  input  logic [N_SPR-1:0][11:0]                   rgb_pixel,
  output logic                                     frame_tick
);

`ifdef SPRITE_COLOR_KEY_EN
  localparam bit KeyEn = 1'b1;
`else
  localparam bit KeyEn = 1'b0;
`endif

  localparam int unsigned AddrW = ROW_BITS + COL_BITS;

  // ---------------------------------------------------------------------------------------------
  // Frame-synchronous position latch
  // ---------------------------------------------------------------------------------------------
  logic                   vblnk_q;
  logic                   latch;
  logic                   frame_tick_q;
  logic [N_SPR-1:0][11:0] x_q, y_q;
  logic [N_SPR-1:0]       en_q;

  assign latch = vii.vblnk & ~vblnk_q;

  // vblnk_q resets to 1 so a vblnk already high at reset release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      en_q         <= '0;
    end else begin
      vblnk_q      <= vii.vblnk;
      frame_tick_q <= latch;
      if (latch) begin
        x_q  <= xpos;
        y_q  <= ypos;
        en_q <= spr_en;
      end
    end
  end

  assign frame_tick = frame_tick_q;

  // ---------------------------------------------------------------------------------------------
  // Stage A: hit test and ROM address
  // ---------------------------------------------------------------------------------------------
  logic [N_SPR-1:0]            hit_d, hit_q;
  logic [N_SPR-1:0][AddrW-1:0] addr_d, addr_q;
  logic [COL_BITS-1:0]         off_h;
  logic [ROW_BITS-1:0]         off_v;

  always_comb begin
    hit_d  = '0;
    addr_d = '0;
    off_h  = '0;
    off_v  = '0;
    for (int i = 0; i < N_SPR; i++) begin
      // Only the low bits of the offset reach the ROM, so truncating the difference is exact.
      off_h = COL_BITS'({1'b0, vii.hcount} - x_q[i]);
      off_v = ROW_BITS'({1'b0, vii.vcount} - y_q[i]);
      if (en_q[i] && in_span(vii.hcount, x_q[i], SPR_W) && in_span(vii.vcount, y_q[i], SPR_H)) begin
        hit_d[i]  = 1'b1;
        addr_d[i] = {off_v, off_h};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign pixel_addr = addr_q;

  // ---------------------------------------------------------------------------------------------
  // Hit flags wait out the ROM read so they line up with rgb_pixel
  // ---------------------------------------------------------------------------------------------
  logic [N_SPR-1:0] hit_pipe_q [ROM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ROM_LAT; k++) hit_pipe_q[k] <= '0;
    end else begin
      hit_pipe_q[0] <= hit_q;
      for (int k = 1; k < ROM_LAT; k++) hit_pipe_q[k] <= hit_pipe_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Timing and background: ROM_LAT + 1 stages bring them to stage C; the stage C register
  // supplies the final cycle of the ROM_LAT + 2 total.
  // ---------------------------------------------------------------------------------------------
  vga_tim_t tim_in;
  vga_tim_t tim_c;
  rgb_t     rgb_c;

  assign tim_in = '{vcount: vii.vcount, hcount: vii.hcount, vsync: vii.vsync,
                    hsync: vii.hsync, vblnk: vii.vblnk, hblnk: vii.hblnk};

  vga_pipe_delay #(
    .Depth (ROM_LAT + 1)
  ) u_pipe_delay (
    .clk_i (clk),
    .rst_i (rst),
    .tim_i (tim_in),
    .rgb_i (vii.rgb),
    .tim_o (tim_c),
    .rgb_o (rgb_c)
  );

  // ---------------------------------------------------------------------------------------------
  // Stage C: priority mix
  // ---------------------------------------------------------------------------------------------
  logic [SPR_MAX-1:0] hit_c;
  rgb_t               spr_c [SPR_MAX];
  rgb_t               mix_rgb;
  vga_tim_t           vio_tim_q;
  rgb_t               vio_rgb_q;

  always_comb begin
    hit_c = SPR_MAX'(hit_pipe_q[ROM_LAT-1]);
    for (int i = 0; i < SPR_MAX; i++) spr_c[i] = '0;
    for (int i = 0; i < N_SPR; i++) spr_c[i] = rgb_pixel[i];

    mix_rgb = rgb_c;
    if (!(tim_c.vblnk || tim_c.hblnk)) begin
      // Walk from lowest priority up so the lowest-index opaque hit is the last write.
      for (int i = SPR_MAX - 1; i >= 0; i--) begin
        if (hit_c[i] && !(KeyEn && (spr_c[i] == KEY_RGB))) mix_rgb = spr_c[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vio_tim_q <= '0;
      vio_rgb_q <= '0;
    end else begin
      vio_tim_q <= tim_c;
      vio_rgb_q <= mix_rgb;
    end
  end

  assign vio.vcount = vio_tim_q.vcount;
  assign vio.hcount = vio_tim_q.hcount;
  assign vio.vsync  = vio_tim_q.vsync;
  assign vio.hsync  = vio_tim_q.hsync;
  assign vio.vblnk  = vio_tim_q.vblnk;
  assign vio.hblnk  = vio_tim_q.hblnk;
  assign vio.rgb    = vio_rgb_q;

endmodule
